cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 4, giving the number of FU output buffers competing for the CDB (range 2..8).
REQ-002 SHALL have parameter CDB_LANES, default 2, giving the number of broadcast lanes per cycle; fixed at 2 for this machine.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 fub_valid  input  NUM_FU  per-FU request (head entry of that FU buffer valid).
REQ-006 fub_result  input  NUM_FU x DATA  per-FU result.
REQ-007 fub_tagDest  input  NUM_FU x PHYS_REG  per-FU destination physical register.
REQ-008 fub_bmask  input  NUM_FU x B_MASK  per-FU branch mask.
REQ-009 br_branch_resolved  input  1  a branch resolves this cycle.
REQ-010 br_pred_wrong  input  1  the resolving branch was mispredicted; meaningful only with br_branch_resolved.
REQ-011 br_bs_ptr  input  BS_PTR  branch-stack slot of the resolving branch.
REQ-012 cdb_stall  output  NUM_FU  per-FU stall; 1 = request not taken this cycle, hold it.
REQ-013 cdb_valid  output  CDB_LANES  registered lane valid.
REQ-014 cdb_result  output  CDB_LANES x DATA  registered lane result.
REQ-015 cdb_tag  output  CDB_LANES x PHYS_REG  registered lane tag.
REQ-016 cdb_bmask  output  CDB_LANES x B_MASK  registered lane branch mask.

Function
REQ-017 Each cycle the block SHALL grant up to 2 eligible requesters, choosing in round-robin order starting at index rr_ptr and wrapping from NUM_FU-1 to 0.
REQ-018 A requester is eligible iff fub_valid[i] and not (br_branch_resolved & br_pred_wrong & fub_bmask[i][br_bs_ptr]).
REQ-019 The first grant SHALL go to lane 0 and the second to lane 1; with one grant, lane 1 is invalid.
REQ-020 cdb_stall[i] SHALL be combinational: 1 iff fub_valid[i], eligible, and not granted; squashed or idle requesters SHALL see 0.
REQ-021 Granted entries SHALL appear on cdb_* exactly one cycle after the grant (latency 1), with cdb_valid cleared for unused lanes.
REQ-022 On a correct resolution (resolved & !pred_wrong), bit br_bs_ptr SHALL be cleared in the bmask of entries being registered this cycle.
REQ-023 Lanes already registered are not squashed; the CDB broadcast in the cycle of a misprediction is delivered as-is.
REQ-024 rr_ptr SHALL update to (index of last grant + 1) mod NUM_FU when at least one grant occurs, and SHALL hold otherwise.
REQ-025 When all requesters are squashed, no grant SHALL occur, cdb_valid SHALL be 0 next cycle, and rr_ptr SHALL hold.
REQ-026 With exactly two eligible requesters, both SHALL be granted and neither stalled, regardless of rr_ptr.

Reset
REQ-027 While reset is low: cdb_valid = 0, cdb_result/cdb_tag/cdb_bmask = 0, rr_ptr = 0; cdb_stall reflects inputs combinationally.
REQ-028 Reset asserting mid-operation SHALL clear registered lanes immediately, with no broadcast on the following edge.

Structure
REQ-029 DATA, PHYS_REG, B_MASK, BS_PTR and a CDB lane entry struct (valid, result, tag, bmask) SHALL live in the shared package.
REQ-030 One sub-module rr_pick SHALL implement the find-first-from-pointer priority selector, instantiated twice (second with the first winner masked).
REQ-031 Target size 120-400 RTL lines; no memories; all outputs from flops except cdb_stall.

Verification
REQ-032 Reset low, then release, no requests -> cdb_valid=00 and cdb_stall=0000 for 3 cycles.
REQ-033 rr_ptr=0, fub_valid=1111 for 2 cycles -> cycle 1 grants FU0,FU1 with cdb_stall=1100; cycle 2 grants FU2,FU3; cdb tags match on each following cycle.
REQ-034 fub_valid=0100, tag 17, result 0xDEAD -> next cycle lane0 valid, tag 17, result 0xDEAD, lane1 invalid, rr_ptr=3.
REQ-035 fub_valid=1010, bmask[1]=0001, bmask[3]=0000, mispredict with br_bs_ptr=0 -> only FU3 granted, cdb_stall=0000, lane0 tag = FU3 tag.
REQ-036 fub_valid=0011, bmask bit 2 set on both, correct resolve with br_bs_ptr=2 -> both broadcast next cycle with cdb_bmask bit 2 = 0.
REQ-037 Assert reset while cdb_valid=11 -> cdb_valid=00 before the next edge, rr_ptr=0 after release.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, the CDB lane entry type and the lane-entry builder used by the
// common-data-bus arbiter.
package cdb_arbiter_pkg;

  localparam int DATA     = 32;
  localparam int PHYS_REG = 6;
  localparam int B_MASK   = 4;
  localparam int BS_PTR   = 2;

  typedef logic [DATA-1:0]     data_t;
  typedef logic [PHYS_REG-1:0] tag_t;
  typedef logic [B_MASK-1:0]   bmask_t;
  typedef logic [BS_PTR-1:0]   bs_ptr_t;

  typedef struct packed {
    logic   valid;
    data_t  result;
    tag_t   tag;
    bmask_t bmask;
  } cdb_entry_t;

  // A correctly resolved branch no longer shadows the result, so its bit is dropped.
  function automatic cdb_entry_t build_entry(input data_t   result,
                                             input tag_t    tag,
                                             input bmask_t  bmask,
                                             input logic    clear_en,
                                             input bs_ptr_t bs_ptr);
    cdb_entry_t e;
    e.valid  = 1'b1;
    e.result = result;
    e.tag    = tag;
    e.bmask  = bmask;
    if (clear_en) e.bmask[bs_ptr] = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle of FU-buffer requests, branch-resolution inputs and CDB broadcast lanes.
// The master side is the pipeline; the slave side is the arbiter.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU    = 4,
  parameter int CDB_LANES = 2
);

  logic   [NUM_FU-1:0]    fub_valid;
  data_t  [NUM_FU-1:0]    fub_result;
  tag_t   [NUM_FU-1:0]    fub_tagDest;
  bmask_t [NUM_FU-1:0]    fub_bmask;

  logic                   br_branch_resolved;
  logic                   br_pred_wrong;
  bs_ptr_t                br_bs_ptr;

  logic   [NUM_FU-1:0]    cdb_stall;
  logic   [CDB_LANES-1:0] cdb_valid;
  data_t  [CDB_LANES-1:0] cdb_result;
  tag_t   [CDB_LANES-1:0] cdb_tag;
  bmask_t [CDB_LANES-1:0] cdb_bmask;

  modport master (
    output fub_valid, fub_result, fub_tagDest, fub_bmask,
    output br_branch_resolved, br_pred_wrong, br_bs_ptr,
    input  cdb_stall, cdb_valid, cdb_result, cdb_tag, cdb_bmask
  );

  modport slave (
    input  fub_valid, fub_result, fub_tagDest, fub_bmask,
    input  br_branch_resolved, br_pred_wrong, br_bs_ptr,
    output cdb_stall, cdb_valid, cdb_result, cdb_tag, cdb_bmask
  );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Find-first-set selector that starts its search at ptr and wraps from N-1 to 0.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [PTR_W-1:0] gnt_idx
);

  int idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional write; a path that leaves one unassigned infers a latch.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-lane round-robin CDB arbiter: picks up to two eligible FU buffers per cycle,
// drops requests squashed by a mispredict and registers winners onto the CDB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU    = 4,
  parameter int CDB_LANES = 2
) (
  input  logic         clk,
  input  logic         reset,
  cdb_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_FU);
  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t                       rr_ptr_d, rr_ptr_q;
  cdb_entry_t [CDB_LANES-1:0] lane_d, lane_q;

  logic [NUM_FU-1:0] squash;
  logic [NUM_FU-1:0] eligible;
  logic [NUM_FU-1:0] second_req;
  logic [NUM_FU-1:0] grant_mask;
  logic              gnt0_valid, gnt1_valid;
  ptr_t              gnt0_idx, gnt1_idx, last_idx;
  logic              clear_en;

  always_comb begin
    squash = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      squash[i] = bus.br_branch_resolved & bus.br_pred_wrong &
                  bus.fub_bmask[i][bus.br_bs_ptr];
    end
  end

  assign eligible = bus.fub_valid & ~squash;
  assign clear_en = bus.br_branch_resolved & ~bus.br_pred_wrong;

  rr_pick #(.N(NUM_FU), .PTR_W(PTR_W)) u_pick0 (
    .req       (eligible),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt0_valid),
    .gnt_idx   (gnt0_idx)
  );

  // Same start pointer with the first winner removed yields the next one in order.
  always_comb begin
    second_req = eligible;
    if (gnt0_valid) second_req[gnt0_idx] = 1'b0;
  end

  rr_pick #(.N(NUM_FU), .PTR_W(PTR_W)) u_pick1 (
    .req       (second_req),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt1_valid),
    .gnt_idx   (gnt1_idx)
  );

  always_comb begin
    grant_mask = '0;
    if (gnt0_valid) grant_mask[gnt0_idx] = 1'b1;
    if (gnt1_valid) grant_mask[gnt1_idx] = 1'b1;
  end

  // Squashed and idle requesters are never told to hold.
  assign bus.cdb_stall = eligible & ~grant_mask;

  always_comb begin
    last_idx = gnt1_valid ? gnt1_idx : gnt0_idx;
    rr_ptr_d = rr_ptr_q;
    if (gnt0_valid) begin
      rr_ptr_d = (int'(last_idx) == NUM_FU - 1) ? '0 : last_idx + ptr_t'(1);
    end
  end

  always_comb begin
    lane_d = '0;
    if (gnt0_valid) begin
      lane_d[0] = build_entry(bus.fub_result[gnt0_idx], bus.fub_tagDest[gnt0_idx],
                              bus.fub_bmask[gnt0_idx], clear_en, bus.br_bs_ptr);
    end
    if (gnt1_valid) begin
      lane_d[1] = build_entry(bus.fub_result[gnt1_idx], bus.fub_tagDest[gnt1_idx],
                              bus.fub_bmask[gnt1_idx], clear_en, bus.br_bs_ptr);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of the others. Reset clears the payload too, not only valid,
  // so the CDB bus reads as all-zero while held in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      lane_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      lane_q   <= lane_d;
    end
  end

  always_comb begin
    bus.cdb_valid  = '0;
    bus.cdb_result = '0;
    bus.cdb_tag    = '0;
    bus.cdb_bmask  = '0;
    for (int l = 0; l < CDB_LANES; l++) begin
      bus.cdb_valid[l]  = lane_q[l].valid;
      bus.cdb_result[l] = lane_q[l].result;
      bus.cdb_tag[l]    = lane_q[l].tag;
      bus.cdb_bmask[l]  = lane_q[l].bmask;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: hand-computed grants, stalls and lane contents.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  cdb_arbiter_if #(.NUM_FU(4), .CDB_LANES(2)) bus ();

  cdb_arbiter #(.NUM_FU(4), .CDB_LANES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_defaults();
    for (int i = 0; i < 4; i++) begin
      bus.fub_result[i]  = data_t'(32'h100 + i);
      bus.fub_tagDest[i] = tag_t'(10 + i);
      bus.fub_bmask[i]   = '0;
    end
    bus.fub_valid          = '0;
    bus.br_branch_resolved = 1'b0;
    bus.br_pred_wrong      = 1'b0;
    bus.br_bs_ptr          = '0;
  endtask

  task automatic drive_edge();
    @(negedge clk);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    set_defaults();

    // Held in reset: registered lanes zero, stall purely combinational.
    after_edge();
    check("rst_valid", bus.cdb_valid, 2'b00);
    check("rst_tag0", bus.cdb_tag[0], '0);
    check("rst_result0", bus.cdb_result[0], '0);
    check("rst_stall_idle", bus.cdb_stall, 4'b0000);

    // Release with no requests: three quiet cycles.
    drive_edge();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      after_edge();
      check("idle_valid", bus.cdb_valid, 2'b00);
      check("idle_stall", bus.cdb_stall, 4'b0000);
    end

    // All four requesting from rr_ptr=0: FU0/FU1 then FU2/FU3.
    drive_edge();
    bus.fub_valid = 4'b1111;
    #1 check("all4_c1_stall", bus.cdb_stall, 4'b1100);
    after_edge();
    check("all4_c1_valid", bus.cdb_valid, 2'b11);
    check("all4_c1_tag0", bus.cdb_tag[0], 6'd10);
    check("all4_c1_tag1", bus.cdb_tag[1], 6'd11);
    drive_edge();
    #1 check("all4_c2_stall", bus.cdb_stall, 4'b0011);
    after_edge();
    check("all4_c2_valid", bus.cdb_valid, 2'b11);
    check("all4_c2_tag0", bus.cdb_tag[0], 6'd12);
    check("all4_c2_tag1", bus.cdb_tag[1], 6'd13);

    // Single request from FU2; rr_ptr then moves to 3.
    drive_edge();
    bus.fub_valid      = 4'b0100;
    bus.fub_tagDest[2] = 6'd17;
    bus.fub_result[2]  = 32'hDEAD;
    #1 check("single_stall", bus.cdb_stall, 4'b0000);
    after_edge();
    check("single_valid", bus.cdb_valid, 2'b01);
    check("single_tag0", bus.cdb_tag[0], 6'd17);
    check("single_result0", bus.cdb_result[0], 32'hDEAD);

    // rr_ptr=3 shows up as FU3 then FU0 winning; rr_ptr becomes 1.
    drive_edge();
    bus.fub_valid = 4'b1111;
    #1 check("wrap_stall", bus.cdb_stall, 4'b0110);
    after_edge();
    check("wrap_tag0", bus.cdb_tag[0], 6'd13);
    check("wrap_tag1", bus.cdb_tag[1], 6'd10);

    // Mispredict squashes every requester: no grant, registered lanes untouched.
    drive_edge();
    set_defaults();
    bus.fub_valid          = 4'b1010;
    bus.fub_bmask[1]       = 4'b0001;
    bus.fub_bmask[3]       = 4'b0001;
    bus.br_branch_resolved = 1'b1;
    bus.br_pred_wrong      = 1'b1;
    bus.br_bs_ptr          = 2'd0;
    #1 check("squash_all_stall", bus.cdb_stall, 4'b0000);
    check("squash_asis_valid", bus.cdb_valid, 2'b11);
    after_edge();
    check("squash_all_valid", bus.cdb_valid, 2'b00);

    // rr_ptr held at 1: FU1/FU2 win, rr_ptr becomes 3.
    drive_edge();
    set_defaults();
    bus.fub_valid = 4'b1111;
    #1 check("hold_stall", bus.cdb_stall, 4'b1001);
    after_edge();
    check("hold_tag0", bus.cdb_tag[0], 6'd11);
    check("hold_tag1", bus.cdb_tag[1], 6'd12);

    // FU1 squashed, FU3 granted alone; rr_ptr becomes 0.
    drive_edge();
    bus.fub_valid          = 4'b1010;
    bus.fub_bmask[1]       = 4'b0001;
    bus.br_branch_resolved = 1'b1;
    bus.br_pred_wrong      = 1'b1;
    bus.br_bs_ptr          = 2'd0;
    #1 check("squash1_stall", bus.cdb_stall, 4'b0000);
    after_edge();
    check("squash1_valid", bus.cdb_valid, 2'b01);
    check("squash1_tag0", bus.cdb_tag[0], 6'd13);

    // Correct resolve on slot 2 clears bit 2 of the broadcast masks; rr_ptr becomes 2.
    drive_edge();
    set_defaults();
    bus.fub_valid          = 4'b0011;
    bus.fub_bmask[0]       = 4'b0100;
    bus.fub_bmask[1]       = 4'b0110;
    bus.br_branch_resolved = 1'b1;
    bus.br_pred_wrong      = 1'b0;
    bus.br_bs_ptr          = 2'd2;
    #1 check("resolve_stall", bus.cdb_stall, 4'b0000);
    after_edge();
    check("resolve_valid", bus.cdb_valid, 2'b11);
    check("resolve_bmask0", bus.cdb_bmask[0], 4'b0000);
    check("resolve_bmask1", bus.cdb_bmask[1], 4'b0010);

    // Two eligible with rr_ptr=2: both granted, FU3 first; rr_ptr becomes 1.
    drive_edge();
    set_defaults();
    bus.fub_valid = 4'b1001;
    #1 check("pair_stall", bus.cdb_stall, 4'b0000);
    after_edge();
    check("pair_valid", bus.cdb_valid, 2'b11);
    check("pair_tag0", bus.cdb_tag[0], 6'd13);
    check("pair_tag1", bus.cdb_tag[1], 6'd10);

    // Reset asserted mid-cycle while both lanes are live.
    drive_edge();
    bus.fub_valid = 4'b1111;
    #1 check("prerst_stall", bus.cdb_stall, 4'b1001);
    after_edge();
    check("prerst_valid", bus.cdb_valid, 2'b11);
    #1 reset = 1'b0;
    #1 check("midrst_valid", bus.cdb_valid, 2'b00);
    check("midrst_tag1", bus.cdb_tag[1], '0);
    after_edge();
    check("inrst_valid", bus.cdb_valid, 2'b00);
    check("inrst_stall", bus.cdb_stall, 4'b1100);
    drive_edge();
    reset = 1'b1;
    #1 check("postrst_stall", bus.cdb_stall, 4'b1100);
    after_edge();
    check("postrst_tag0", bus.cdb_tag[0], 6'd10);
    check("postrst_tag1", bus.cdb_tag[1], 6'd11);

    drive_edge();
    set_defaults();
    after_edge();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
